// File: rtl/painterengine_gpu_fill_source.sv
// Fill-pattern word source for a DMA writer channel: emits a constant or
// incrementing stream of 32-bit words with stall-timeout and zero-length errors.
module painterengine_gpu_fill_source #(
    parameter int unsigned PARAM_TIMEOUT_CYCLES = 65535
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_start,
    input  logic [31:0] i_wire_length,
    input  logic [31:0] i_wire_color,
    input  logic [31:0] i_wire_step,
    input  logic        i_wire_mode,
    output logic [31:0] o_wire_data,
    output logic        o_wire_data_valid,
    input  logic        i_wire_data_next,
    output logic        o_wire_busy,
    output logic        o_wire_done,
    output logic        o_wire_error,
    output logic [1:0]  o_wire_error_type,
    output logic [1:0]  o_wire_debug_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ZERO  = 2'b01;
    localparam logic [1:0] ERR_STALL = 2'b10;
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(PARAM_TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] remaining_q, remaining_d;
    logic [15:0] stall_q, stall_d;
    logic [31:0] step_q, step_d;
    logic        mode_q, mode_d;
    logic [1:0]  error_type_q, error_type_d;
    logic [16:0] stall_inc;

    // One extra bit so a limit of 65535 is reachable without wrap.
    assign stall_inc = {1'b0, stall_q} + 17'd1;

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            remaining_q  <= '0;
            stall_q      <= '0;
            step_q       <= '0;
            mode_q       <= 1'b0;
            error_type_q <= ERR_OK;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            remaining_q  <= remaining_d;
            stall_q      <= stall_d;
            step_q       <= step_d;
            mode_q       <= mode_d;
            error_type_q <= error_type_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        remaining_d  = remaining_q;
        stall_d      = stall_q;
        step_d       = step_q;
        mode_d       = mode_q;
        error_type_d = error_type_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_wire_start) begin
                    if (i_wire_length == 32'd0) begin
                        state_d      = ST_ERROR;
                        error_type_d = ERR_ZERO;
                    end else begin
                        state_d      = ST_RUN;
                        data_d       = i_wire_color;
                        remaining_d  = i_wire_length;
                        step_d       = i_wire_step;
                        mode_d       = i_wire_mode;
                        stall_d      = '0;
                        error_type_d = ERR_OK;
                    end
                end
            end
            ST_RUN: begin
                // A consume in the cycle the limit is reached takes priority.
                if (i_wire_data_next) begin
                    remaining_d = remaining_q - 32'd1;
                    stall_d     = '0;
                    if (mode_q) data_d = data_q + step_q;
                    if (remaining_q == 32'd1) state_d = ST_DONE;
                end else begin
                    stall_d = stall_inc[15:0];
                    if (stall_inc == TIMEOUT_LIMIT) begin
                        state_d      = ST_ERROR;
                        error_type_d = ERR_STALL;
                    end
                end
            end
            ST_ERROR: begin
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_wire_data        = data_q;
    assign o_wire_data_valid  = (state_q == ST_RUN);
    assign o_wire_busy        = (state_q == ST_RUN);
    assign o_wire_done        = (state_q == ST_DONE);
    assign o_wire_error       = (state_q == ST_ERROR);
    assign o_wire_error_type  = error_type_q;
    assign o_wire_debug_state = state_q;

endmodule

// File: tb/tb_painterengine_gpu_fill_source.sv
// Directed bench for the fill source: expected words are queued at start and
// popped by a monitor whenever the DUT hands a word to the consumer.
module tb_painterengine_gpu_fill_source;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] length = '0;
    logic [31:0] color = '0;
    logic [31:0] step = '0;
    logic        mode = 1'b0;
    logic        next = 1'b0;
    logic [31:0] data;
    logic        valid, busy, done, error;
    logic [1:0]  etype, dbg_state;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    painterengine_gpu_fill_source #(.PARAM_TIMEOUT_CYCLES(8)) dut (
        .i_wire_clock      (clk),
        .i_wire_resetn     (resetn),
        .i_wire_start      (start),
        .i_wire_length     (length),
        .i_wire_color      (color),
        .i_wire_step       (step),
        .i_wire_mode       (mode),
        .o_wire_data       (data),
        .o_wire_data_valid (valid),
        .i_wire_data_next  (next),
        .o_wire_busy       (busy),
        .o_wire_done       (done),
        .o_wire_error      (error),
        .o_wire_error_type (etype),
        .o_wire_debug_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Consumer side: a word is taken at the next edge when valid && next.
    always @(negedge clk) begin
        if (resetn && valid && next) begin
            check("word_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("word", data, exp_q.pop_front());
        end
    end

    task automatic start_run(input logic [31:0] len, input logic [31:0] col,
                             input logic [31:0] stp, input logic md, input bit push);
        logic [31:0] w;
        @(posedge clk) #1;
        length = len; color = col; step = stp; mode = md; start = 1'b1;
        if (push) begin
            w = col;
            for (int i = 0; i < int'(len); i++) begin
                exp_q.push_back(w);
                if (md) w = w + stp;
            end
        end
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(done || error) && cyc < 200);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, data, 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_etype"}, 32'(etype), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int cyc;
        int zeros;
        int busy_cyc;
        logic [31:0] len;

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk) #1 resetn = 1'b1;

        // Constant fill, next held high (ignored while valid is low)
        next = 1'b1;
        start_run(32'd4, 32'hFF00FF00, 32'h0, 1'b0, 1'b1);
        wait_end(cyc);
        check("const_cycles", 32'(cyc), 32'd5);
        check("const_done", 32'(done), 32'd1);
        check("const_valid", 32'(valid), 32'd0);
        check("const_left", 32'(exp_q.size()), 32'd0);

        // Incrementing fill with wrap, restarted from DONE; inputs scrambled after start
        start_run(32'd3, 32'hFFFFFFFE, 32'd1, 1'b1, 1'b1);
        check("restart_etype", 32'(etype), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        color = $urandom; step = $urandom; mode = 1'b0; length = $urandom_range(1, 100);
        wait_end(cyc);
        check("incr_cycles", 32'(cyc), 32'd4);
        check("incr_done", 32'(done), 32'd1);
        check("incr_left", 32'(exp_q.size()), 32'd0);

        // Backpressure: next 1,0,0,1
        next = 1'b0;
        start_run(32'd2, 32'h12345678, 32'h10, 1'b1, 1'b1);
        next = 1'b1;
        @(posedge clk) #1 next = 1'b0;
        @(negedge clk) check("bp_hold1", data, 32'h12345688);
        @(posedge clk) #1 next = 1'b0;
        @(negedge clk) check("bp_hold2", data, 32'h12345688);
        check("bp_valid", 32'(valid), 32'd1);
        @(posedge clk) #1 next = 1'b1;
        wait_end(cyc);
        check("bp_cycles", 32'(cyc), 32'd2);
        check("bp_done", 32'(done), 32'd1);
        check("bp_left", 32'(exp_q.size()), 32'd0);

        // Random runs with random backpressure (never long enough to time out)
        for (int r = 0; r < 4; r++) begin
            len = 32'($urandom_range(1, 6));
            start_run(len, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            zeros = 0;
            cyc = 0;
            while (!done && cyc < 200) begin
                @(posedge clk) #1;
                if (done) break;
                next = ($urandom_range(0, 2) != 0) || (zeros >= 4);
                zeros = next ? 0 : zeros + 1;
                cyc++;
            end
            check("rand_done", 32'(done), 32'd1);
            check("rand_left", 32'(exp_q.size()), 32'd0);
        end

        // Reset mid-run after two words
        next = 1'b1;
        start_run(32'd10, 32'hA0000000, 32'd3, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk) #2 resetn = 1'b0;
        #1 check_all_zero("midrst");
        check("midrst_left", 32'(exp_q.size()), 32'd8);
        exp_q.delete();
        @(posedge clk) #1 resetn = 1'b1;
        @(negedge clk) check("post_rst_state", 32'(dbg_state), 32'd0);
        check("post_rst_valid", 32'(valid), 32'd0);

        // Restart to DONE, then again from DONE with a new color
        start_run(32'd2, 32'h00000011, 32'd0, 1'b0, 1'b1);
        wait_end(cyc);
        check("rs1_done", 32'(done), 32'd1);
        start_run(32'd3, 32'hC0FFEE00, 32'd2, 1'b1, 1'b1);
        wait_end(cyc);
        check("rs2_cycles", 32'(cyc), 32'd4);
        check("rs2_left", 32'(exp_q.size()), 32'd0);

        // Zero length, then a start that must be ignored
        start_run(32'd0, 32'h1, 32'h1, 1'b0, 1'b1);
        check("zero_error", 32'(error), 32'd1);
        check("zero_etype", 32'(etype), 32'd1);
        check("zero_valid", 32'(valid), 32'd0);
        start_run(32'd3, 32'h5, 32'h1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("sticky_error", 32'(error), 32'd1);
        check("sticky_etype", 32'(etype), 32'd1);
        check("sticky_busy", 32'(busy), 32'd0);
        check("sticky_valid", 32'(valid), 32'd0);

        // Stall timeout; a consume on the limit cycle restarts the count
        @(posedge clk) #1 resetn = 1'b0;
        @(posedge clk) #1 resetn = 1'b1;
        next = 1'b0;
        start_run(32'd5, 32'h0BADF00D, 32'd0, 1'b0, 1'b1);
        repeat (7) @(posedge clk);
        #1 check("stall_pre_busy", 32'(busy), 32'd1);
        next = 1'b1;
        @(posedge clk) #1 next = 1'b0;
        busy_cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cyc++;
        end
        check("stall_cycles", 32'(busy_cyc), 32'd8);
        check("stall_error", 32'(error), 32'd1);
        check("stall_etype", 32'(etype), 32'd2);
        check("stall_valid", 32'(valid), 32'd0);
        check("stall_left", 32'(exp_q.size()), 32'd4);
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/painterengine_gpu_fill_source.md
PAINTERENGINE_GPU_FILL_SOURCE -- requirements
Module: painterengine_gpu_fill_source

Interface
REQ-001 The block SHALL have parameter PARAM_TIMEOUT_CYCLES, default 65535: number of consecutive RUN cycles without a consumed word before a stall error.
REQ-002 i_wire_clock  input  1  clock; all state updates on its rising edge.
REQ-003 i_wire_resetn  input  1  reset, asynchronous, active-low.
REQ-004 i_wire_start  input  1  single-cycle start pulse.
REQ-005 i_wire_length  input  32  number of 32-bit words to produce.
REQ-006 i_wire_color  input  32  first data word.
REQ-007 i_wire_step  input  32  per-word increment used in mode 1.
REQ-008 i_wire_mode  input  1  0 = constant fill, 1 = incrementing fill.
REQ-009 o_wire_data  output  32  current word presented to the downstream DMA writer channel.
REQ-010 o_wire_data_valid  output  1  o_wire_data holds a word not yet consumed.
REQ-011 i_wire_data_next  input  1  downstream consumed the current word this cycle.
REQ-012 o_wire_busy  output  1  high in RUN.
REQ-013 o_wire_done  output  1  high in DONE.
REQ-014 o_wire_error  output  1  high in ERROR.
REQ-015 o_wire_error_type  output  2  00 ok, 01 zero length, 10 stall timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, DONE and ERROR; the status outputs SHALL be decoded combinationally from the state register.
REQ-017 In IDLE or DONE, i_wire_start=1 with i_wire_length!=0 SHALL latch color into the data register, length into a 32-bit remaining counter, and step and mode into internal registers; the FSM SHALL then enter RUN, with o_wire_data_valid=1 on the next cycle.
REQ-018 In IDLE or DONE, i_wire_start=1 with i_wire_length==0 SHALL enter ERROR with error_type 01.
REQ-019 In RUN, o_wire_data_valid SHALL be 1 and o_wire_data SHALL equal the data register.
REQ-020 In RUN, i_wire_data_next=1 SHALL consume one word, with these effects on the next edge:
- remaining decrements by 1;
- the data register becomes data+step (mod 2^32) when latched mode=1, and is unchanged when mode=0.
REQ-021 A consumed word with remaining==1 SHALL move the FSM to DONE, with o_wire_data_valid=0 on the following cycle; zero-bubble back-to-back consumption SHALL be supported.
REQ-022 i_wire_data_next=1 while o_wire_data_valid=0 SHALL be ignored.
REQ-023 i_wire_start while in RUN SHALL be ignored.
REQ-024 Changes to length, color, step or mode after start SHALL NOT affect the current run.
REQ-025 A 16-bit stall counter SHALL behave as follows:
- cleared on entry to RUN and on every consumed word;
- incremented on each RUN cycle with i_wire_data_next=0;
- on reaching PARAM_TIMEOUT_CYCLES, the FSM SHALL enter ERROR with error_type 10.
REQ-026 Simultaneous stall-limit and consume in the same cycle: the consume SHALL win and clear the counter.
REQ-027 ERROR SHALL be sticky until reset, with o_wire_data_valid=0; start SHALL be ignored in ERROR.
REQ-028 In DONE, o_wire_done SHALL stay high until the next accepted start; on that start, error_type SHALL remain 00.

Reset
REQ-029 While i_wire_resetn=0, the block SHALL hold state IDLE and all outputs 0: o_wire_data=0, valid=0, busy=0, done=0, error=0, error_type=00; the remaining, stall, step and mode registers SHALL also be 0.
REQ-030 Reset asserted mid-RUN SHALL drop o_wire_data_valid asynchronously without completing the run; after release, the FSM SHALL sit in IDLE awaiting start.

Verification
REQ-031 Constant fill: mode=0, color=0xFF00FF00, length=4, next held 1 -> four words of 0xFF00FF00 on consecutive cycles, then done=1 and valid=0.
REQ-032 Increment fill: mode=1, color=0xFFFFFFFE, step=1, length=3 -> words 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap), then done.
REQ-033 Backpressure: length=2, next toggled 1,0,0,1 -> exactly two words consumed with data held stable across the stall cycles, then done.
REQ-034 Zero length: start with length=0 -> error=1, error_type=01; a later start is ignored.
REQ-035 Stall timeout (PARAM_TIMEOUT_CYCLES=8): start with length=5, next held 0 -> error=1, error_type=10 after 8 RUN cycles; valid=0 afterwards.
REQ-036 Reset mid-run and restart: reset asserted after 2 of 10 words -> all outputs 0 immediately; restart from DONE with new color -> new sequence with no residual words.
